// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter
//
// Shares one DDR datamover (an mm2s read channel and an s2mm write channel)
// among NUM_CH requesters. Only one burst is in flight at any time.
// Arbitration is round-robin, and a channel that holds both requests gets
// its write first. Once a channel has been served it must drop its requests
// before it can win again.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   ch_rd_en / ch_rd_addr           level read request and address, per channel
//   ch_rd_done                      one-cycle read-complete pulse, per channel
//   rd_buffer                       shared read data, beat 0 in the LSBs
//   ch_wr_en / ch_wr_addr           level write request and address, per channel
//   ch_wr_buffer                    write burst data, per channel
//   ch_wr_done                      one-cycle write-complete pulse, per channel
//   mm2s_addr/addrvalid/addrready   read command handshake
//   mm2s_tdata/tvalid/tlast/tready  read beat stream
//   s2mm_addr/addrvalid/addrready   write command handshake
//   s2mm_tdata/tvalid/tlast/tready  write beat stream
//   busy                            a transaction is in progress
//   grant_ch                        channel currently served
//   err_tlast                       sticky flag: read tlast arrived on the wrong beat
module ddr_req_arbiter #(
  parameter  int NUM_CH      = 4,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int BURST_LEN   = 8,
  parameter  int TDATA_WIDTH = 128,
  localparam int BUF_LEN     = BURST_LEN * TDATA_WIDTH,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            ch_rd_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_rd_addr,
  output logic [NUM_CH-1:0]            ch_rd_done,
  output logic [BUF_LEN-1:0]           rd_buffer,
  input  logic [NUM_CH-1:0]            ch_wr_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_wr_addr,
  input  logic [NUM_CH*BUF_LEN-1:0]    ch_wr_buffer,
  output logic [NUM_CH-1:0]            ch_wr_done,
  output logic [ADDR_WIDTH-1:0]        mm2s_addr,
  output logic                         mm2s_addrvalid,
  input  logic                         mm2s_addrready,
  input  logic [TDATA_WIDTH-1:0]       mm2s_tdata,
  input  logic                         mm2s_tvalid,
  input  logic                         mm2s_tlast,
  output logic                         mm2s_tready,
  output logic [ADDR_WIDTH-1:0]        s2mm_addr,
  output logic                         s2mm_addrvalid,
  input  logic                         s2mm_addrready,
  output logic [TDATA_WIDTH-1:0]       s2mm_tdata,
  output logic                         s2mm_tvalid,
  output logic                         s2mm_tlast,
  input  logic                         s2mm_tready,
  output logic                         busy,
  output logic [CH_W-1:0]              grant_ch,
  output logic                         err_tlast
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_DONE
  } state_t;

  state_t                  state_reg;
  logic [CH_W-1:0]         rr_reg;
  logic [CH_W-1:0]         grant_ch_reg;
  logic                    is_wr_reg;
  logic [CNT_W-1:0]        beat_cnt_reg;
  logic [BUF_LEN-1:0]      wr_buf_reg;
  logic [BUF_LEN-1:0]      rd_buffer_reg;
  logic [NUM_CH-1:0]       served_reg;
  logic [NUM_CH-1:0]       served_next;
  logic [NUM_CH-1:0]       req_elig;
  logic [NUM_CH-1:0]       rd_done_reg;
  logic [NUM_CH-1:0]       wr_done_reg;
  logic [ADDR_WIDTH-1:0]   mm2s_addr_reg;
  logic                    mm2s_addrvalid_reg;
  logic                    mm2s_tready_reg;
  logic [ADDR_WIDTH-1:0]   s2mm_addr_reg;
  logic                    s2mm_addrvalid_reg;
  logic [TDATA_WIDTH-1:0]  s2mm_tdata_reg;
  logic                    s2mm_tvalid_reg;
  logic                    s2mm_tlast_reg;
  logic                    busy_reg;
  logic                    err_tlast_reg;

  logic                    arb_found;
  logic [CH_W-1:0]         arb_ch;
  logic                    arb_is_wr;
  logic                    beat_last;
  int                      beat_nxt;

  // Channel index (base + off) wrapped into 0..NUM_CH-1; off < NUM_CH.
  function automatic logic [CH_W-1:0] rr_pick(input logic [CH_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return sum[CH_W-1:0];
  endfunction

  // Served flag: set by the channel's own done pulse, cleared once the
  // channel is seen with both requests low. The done pulse wins so a channel
  // that already released its requests still cannot retrigger on stale state.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign req_elig[gi]    = (ch_rd_en[gi] | ch_wr_en[gi]) & ~served_reg[gi];
      assign served_next[gi] = ((state_reg == S_DONE) && (grant_ch_reg == CH_W'(gi))) ? 1'b1 :
                               (!(ch_rd_en[gi] | ch_wr_en[gi]))                      ? 1'b0 :
                               served_reg[gi];
    end
  endgenerate

  // The first eligible channel at or after rr wins.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    arb_is_wr = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (!arb_found && req_elig[rr_pick(rr_reg, off)]) begin
        arb_found = 1'b1;
        arb_ch    = rr_pick(rr_reg, off);
        arb_is_wr = ch_wr_en[rr_pick(rr_reg, off)];
      end
    end
  end

  always_comb begin
    beat_last = (int'(beat_cnt_reg) == BURST_LEN - 1);
    beat_nxt  = int'(beat_cnt_reg) + 1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      served_reg <= '0;
    end else begin
      served_reg <= served_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg          <= S_IDLE;
      rr_reg             <= '0;
      grant_ch_reg       <= '0;
      is_wr_reg          <= 1'b0;
      beat_cnt_reg       <= '0;
      wr_buf_reg         <= '0;
      rd_buffer_reg      <= '0;
      rd_done_reg        <= '0;
      wr_done_reg        <= '0;
      mm2s_addr_reg      <= '0;
      mm2s_addrvalid_reg <= 1'b0;
      mm2s_tready_reg    <= 1'b0;
      s2mm_addr_reg      <= '0;
      s2mm_addrvalid_reg <= 1'b0;
      s2mm_tdata_reg     <= '0;
      s2mm_tvalid_reg    <= 1'b0;
      s2mm_tlast_reg     <= 1'b0;
      busy_reg           <= 1'b0;
      err_tlast_reg      <= 1'b0;
    end else begin
      rd_done_reg <= '0;
      wr_done_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (arb_found) begin
            grant_ch_reg <= arb_ch;
            rr_reg       <= (arb_ch == CH_W'(NUM_CH - 1)) ? '0 : arb_ch + 1'b1;
            is_wr_reg    <= arb_is_wr;
            beat_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            if (arb_is_wr) begin
              s2mm_addr_reg      <= ch_wr_addr[arb_ch*ADDR_WIDTH +: ADDR_WIDTH];
              wr_buf_reg         <= ch_wr_buffer[arb_ch*BUF_LEN +: BUF_LEN];
              s2mm_addrvalid_reg <= 1'b1;
              state_reg          <= S_WR_ADDR;
            end else begin
              mm2s_addr_reg      <= ch_rd_addr[arb_ch*ADDR_WIDTH +: ADDR_WIDTH];
              mm2s_addrvalid_reg <= 1'b1;
              state_reg          <= S_RD_ADDR;
            end
          end
        end

        S_RD_ADDR: begin
          if (mm2s_addrready) begin
            mm2s_addrvalid_reg <= 1'b0;
            mm2s_tready_reg    <= 1'b1;
            state_reg          <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (mm2s_tvalid && mm2s_tready_reg) begin
            rd_buffer_reg[int'(beat_cnt_reg)*TDATA_WIDTH +: TDATA_WIDTH] <= mm2s_tdata;
            // The beat count alone ends the burst; tlast is only audited.
            if (mm2s_tlast != beat_last) err_tlast_reg <= 1'b1;
            if (beat_last) begin
              mm2s_tready_reg <= 1'b0;
              state_reg       <= S_DONE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end

        S_WR_ADDR: begin
          if (s2mm_addrready) begin
            s2mm_addrvalid_reg <= 1'b0;
            s2mm_tvalid_reg    <= 1'b1;
            s2mm_tdata_reg     <= wr_buf_reg[TDATA_WIDTH-1:0];
            s2mm_tlast_reg     <= (BURST_LEN == 1);
            state_reg          <= S_WR_DATA;
          end
        end

        S_WR_DATA: begin
          if (s2mm_tvalid_reg && s2mm_tready) begin
            if (beat_last) begin
              s2mm_tvalid_reg <= 1'b0;
              s2mm_tlast_reg  <= 1'b0;
              state_reg       <= S_DONE;
            end else begin
              // Preload the next beat so tdata/tlast stay registered outputs.
              beat_cnt_reg   <= beat_cnt_reg + 1'b1;
              s2mm_tdata_reg <= wr_buf_reg[beat_nxt*TDATA_WIDTH +: TDATA_WIDTH];
              s2mm_tlast_reg <= (beat_nxt == BURST_LEN - 1);
            end
          end
        end

        S_DONE: begin
          if (is_wr_reg) wr_done_reg <= NUM_CH'(1) << grant_ch_reg;
          else           rd_done_reg <= NUM_CH'(1) << grant_ch_reg;
          busy_reg     <= 1'b0;
          beat_cnt_reg <= '0;
          state_reg    <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ch_rd_done     = rd_done_reg;
  assign ch_wr_done     = wr_done_reg;
  assign rd_buffer      = rd_buffer_reg;
  assign mm2s_addr      = mm2s_addr_reg;
  assign mm2s_addrvalid = mm2s_addrvalid_reg;
  assign mm2s_tready    = mm2s_tready_reg;
  assign s2mm_addr      = s2mm_addr_reg;
  assign s2mm_addrvalid = s2mm_addrvalid_reg;
  assign s2mm_tdata     = s2mm_tdata_reg;
  assign s2mm_tvalid    = s2mm_tvalid_reg;
  assign s2mm_tlast     = s2mm_tlast_reg;
  assign busy           = busy_reg;
  assign grant_ch       = grant_ch_reg;
  assign err_tlast      = err_tlast_reg;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb_ddr_req_arbiter
//
// Bench for ddr_req_arbiter. It plays the datamover for both the read
// stream and the write stream. Each test queues the transactions it expects,
// in order. Every done pulse pops one entry and checks the channel, the
// address, the data and, where the path is stall-free, the latency.
module tb_ddr_req_arbiter;

  localparam int NUM_CH = 4;
  localparam int AW     = 32;
  localparam int BL     = 8;
  localparam int TW     = 128;
  localparam int BUF    = BL * TW;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NUM_CH-1:0]     ch_rd_en = '0;
  logic [NUM_CH*AW-1:0]  ch_rd_addr = '0;
  logic [NUM_CH-1:0]     ch_rd_done;
  logic [BUF-1:0]        rd_buffer;
  logic [NUM_CH-1:0]     ch_wr_en = '0;
  logic [NUM_CH*AW-1:0]  ch_wr_addr = '0;
  logic [NUM_CH*BUF-1:0] ch_wr_buffer = '0;
  logic [NUM_CH-1:0]     ch_wr_done;
  logic [AW-1:0]         mm2s_addr;
  logic                  mm2s_addrvalid;
  logic                  mm2s_addrready = 1'b1;
  logic [TW-1:0]         mm2s_tdata = '0;
  logic                  mm2s_tvalid = 1'b0;
  logic                  mm2s_tlast = 1'b0;
  logic                  mm2s_tready;
  logic [AW-1:0]         s2mm_addr;
  logic                  s2mm_addrvalid;
  logic                  s2mm_addrready = 1'b1;
  logic [TW-1:0]         s2mm_tdata;
  logic                  s2mm_tvalid;
  logic                  s2mm_tlast;
  logic                  s2mm_tready = 1'b1;
  logic                  busy;
  logic [1:0]            grant_ch;
  logic                  err_tlast;

  ddr_req_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TDATA_WIDTH(TW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ch_rd_en(ch_rd_en), .ch_rd_addr(ch_rd_addr), .ch_rd_done(ch_rd_done),
    .rd_buffer(rd_buffer),
    .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr), .ch_wr_buffer(ch_wr_buffer),
    .ch_wr_done(ch_wr_done),
    .mm2s_addr(mm2s_addr), .mm2s_addrvalid(mm2s_addrvalid), .mm2s_addrready(mm2s_addrready),
    .mm2s_tdata(mm2s_tdata), .mm2s_tvalid(mm2s_tvalid), .mm2s_tlast(mm2s_tlast),
    .mm2s_tready(mm2s_tready),
    .s2mm_addr(s2mm_addr), .s2mm_addrvalid(s2mm_addrvalid), .s2mm_addrready(s2mm_addrready),
    .s2mm_tdata(s2mm_tdata), .s2mm_tvalid(s2mm_tvalid), .s2mm_tlast(s2mm_tlast),
    .s2mm_tready(s2mm_tready),
    .busy(busy), .grant_ch(grant_ch), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           is_wr;
    int             ch;
    logic [AW-1:0]  addr;
    logic [BUF-1:0] data;
    int             lat;   // -1: latency not checked
  } txn_t;

  txn_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // datamover model / monitor state
  int             cyc = 0;
  int             rd_seed = 0;
  int             tlast_beat = BL - 1;
  bit             tog_mode = 1'b0;
  int             ra_hold = 0;
  int             rd_k = 0;
  bit             rd_act = 1'b0;
  int             wr_k = 0;
  int             first_wb = 0;
  int             last_wb = 0;
  int             grant_cyc = 0;
  logic [1:0]     cur_grant = '0;
  logic [AW-1:0]  cur_addr = '0;
  logic [BUF-1:0] wr_cap = '0;
  bit             busy_prev = 1'b0;
  bit             wr_stall_prev = 1'b0;
  logic [TW-1:0]  wr_hold_data = '0;
  bit             hs_ra, hs_rb, hs_wa, hs_wb;

  task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [BUF-1:0] mk_rd(input int seed);
    logic [BUF-1:0] b;
    for (int k = 0; k < BL; k++) b[k*TW +: TW] = TW'(seed + k);
    return b;
  endfunction

  function automatic logic [BUF-1:0] rnd_buf();
    logic [BUF-1:0] b;
    for (int w = 0; w < BUF/32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic push_txn(input logic is_wr, input int ch, input logic [AW-1:0] addr,
                          input logic [BUF-1:0] data, input int lat);
    txn_t t;
    t.is_wr = is_wr; t.ch = ch; t.addr = addr; t.data = data; t.lat = lat;
    sb_q.push_back(t);
    $display("queued %s ch%0d addr %h", is_wr ? "write" : "read", ch, addr);
  endtask

  task automatic compare_done();
    txn_t e;
    logic [NUM_CH-1:0] oh;
    if (sb_q.size() == 0) begin
      check_val("unexpected_done", TW'({ch_wr_done, ch_rd_done}), '0);
    end else begin
      e  = sb_q.pop_front();
      oh = NUM_CH'(1) << e.ch;
      check_val("done_vec", TW'({ch_wr_done, ch_rd_done}),
                e.is_wr ? TW'({oh, 4'b0000}) : TW'({4'b0000, oh}));
      check_val("grant_ch", TW'(cur_grant), TW'(e.ch));
      check_val("cmd_addr", TW'(cur_addr), TW'(e.addr));
      if (e.lat >= 0) check_val("latency", TW'(cyc - grant_cyc), TW'(e.lat));
      if (e.is_wr) check_val("wr_beats", TW'(wr_k), TW'(BL));
      for (int k = 0; k < BL; k++)
        check_val($sformatf("%s_beat%0d", e.is_wr ? "wr" : "rd", k),
                  e.is_wr ? wr_cap[k*TW +: TW] : rd_buffer[k*TW +: TW], e.data[k*TW +: TW]);
      $display("done %s ch%0d addr %h at cycle %0d", e.is_wr ? "write" : "read", e.ch, cur_addr, cyc);
    end
  endtask

  // Samples on the falling edge, drives 1ns after the rising edge.
  initial begin : model
    forever begin
      @(negedge clk);
      cyc++;
      hs_ra = mm2s_addrvalid && mm2s_addrready;
      hs_rb = mm2s_tvalid && mm2s_tready;
      hs_wa = s2mm_addrvalid && s2mm_addrready;
      hs_wb = s2mm_tvalid && s2mm_tready;
      if (!rstn) begin
        busy_prev     = 1'b0;
        wr_stall_prev = 1'b0;
        wr_k          = 0;
      end else begin
        if (busy && !busy_prev) begin
          grant_cyc = cyc;
          cur_grant = grant_ch;
        end
        busy_prev = busy;
        if (hs_ra) cur_addr = mm2s_addr;
        if (hs_wa) begin
          cur_addr = s2mm_addr;
          wr_k     = 0;
        end
        if (wr_stall_prev) check_val("wr_hold", s2mm_tdata, wr_hold_data);
        wr_stall_prev = s2mm_tvalid && !s2mm_tready;
        wr_hold_data  = s2mm_tdata;
        if (hs_wb) begin
          if (wr_k < BL) wr_cap[wr_k*TW +: TW] = s2mm_tdata;
          check_val($sformatf("wr_tlast%0d", wr_k), TW'(s2mm_tlast), TW'(wr_k == BL - 1));
          if (wr_k == 0) first_wb = cyc;
          last_wb = cyc;
          wr_k++;
        end
        if (ch_rd_done != '0 || ch_wr_done != '0) compare_done();
      end

      @(posedge clk);
      #1;
      if (!rstn) begin
        rd_act = 1'b0;
        rd_k   = 0;
      end else if (hs_ra) begin
        rd_act = 1'b1;
        rd_k   = 0;
      end else if (hs_rb) begin
        rd_k++;
        if (rd_k >= BL) rd_act = 1'b0;
      end
      mm2s_tvalid = rd_act;
      mm2s_tdata  = rd_act ? TW'(rd_seed + rd_k) : '0;
      mm2s_tlast  = rd_act && (rd_k == tlast_beat);
      s2mm_tready = tog_mode ? ~s2mm_tready : 1'b1;
      if (mm2s_addrvalid && ra_hold > 0) begin
        ra_hold--;
        mm2s_addrready = 1'b0;
      end else begin
        mm2s_addrready = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val({tag, "_timeout"}, TW'(sb_q.size()), '0);
      sb_q.delete();
    end
  endtask

  task automatic reset_outputs(input string tag);
    check_val({tag, "_busy"}, TW'(busy), '0);
    check_val({tag, "_grant"}, TW'(grant_ch), '0);
    check_val({tag, "_rd_addrvalid"}, TW'(mm2s_addrvalid), '0);
    check_val({tag, "_wr_addrvalid"}, TW'(s2mm_addrvalid), '0);
    check_val({tag, "_tready"}, TW'(mm2s_tready), '0);
    check_val({tag, "_tvalid"}, TW'(s2mm_tvalid), '0);
    check_val({tag, "_tlast"}, TW'(s2mm_tlast), '0);
    check_val({tag, "_tdata"}, s2mm_tdata, '0);
    check_val({tag, "_done"}, TW'({ch_wr_done, ch_rd_done}), '0);
    check_val({tag, "_err"}, TW'(err_tlast), '0);
    check_val({tag, "_rdbuf"}, rd_buffer[TW-1:0], '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [BUF-1:0] b;
    int n;

    // reset state
    step(3);
    reset_outputs("rst");
    rstn = 1'b1;
    step(2);

    // ch2 read at 0x1000, beats 1..8, done 10 cycles after grant
    ch_rd_addr[2*AW +: AW] = 32'h1000;
    rd_seed = 1;
    push_txn(1'b0, 2, 32'h1000, mk_rd(1), 10);
    ch_rd_en[2] = 1'b1;
    wait_empty("rd_ch2", 100);
    check_val("rd_err_tlast", TW'(err_tlast), '0);
    check_val("rd_beat0_lsb", rd_buffer[TW-1:0], TW'(1));
    ch_rd_en = '0;
    step(2);

    // all channels write from reset: grants 0,1,2,3 then nothing more
    rstn = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      b = rnd_buf();
      ch_wr_buffer[c*BUF +: BUF] = b;
      ch_wr_addr[c*AW +: AW] = 32'h2000 + 32'(c) * 32'h100;
      push_txn(1'b1, c, 32'h2000 + 32'(c) * 32'h100, b, 10);
    end
    ch_wr_en = '1;
    step(2);
    rstn = 1'b1;
    wait_empty("wr_all", 200);
    step(20);
    check_val("all_served_idle", TW'(busy), '0);
    ch_wr_en = '0;
    step(2);

    // ch1 read and write together: write first, read only after re-request
    b = rnd_buf();
    ch_wr_buffer[1*BUF +: BUF] = b;
    ch_wr_addr[1*AW +: AW] = 32'h3100;
    ch_rd_addr[1*AW +: AW] = 32'h3000;
    push_txn(1'b1, 1, 32'h3100, b, 10);
    ch_rd_en[1] = 1'b1;
    ch_wr_en[1] = 1'b1;
    wait_empty("ch1_wr", 100);
    step(20);
    check_val("ch1_served_idle", TW'(busy), '0);
    ch_rd_en = '0;
    ch_wr_en = '0;
    step(2);
    rd_seed = 32'h100;
    push_txn(1'b0, 1, 32'h3000, mk_rd(32'h100), 10);
    ch_rd_en[1] = 1'b1;
    wait_empty("ch1_rd", 100);
    ch_rd_en = '0;
    step(2);

    // s2mm_tready toggling; inputs changed after the grant must not matter
    tog_mode = 1'b1;
    b = rnd_buf();
    ch_wr_buffer[3*BUF +: BUF] = b;
    ch_wr_addr[3*AW +: AW] = 32'h4000;
    push_txn(1'b1, 3, 32'h4000, b, -1);
    ch_wr_en[3] = 1'b1;
    step(2);
    ch_wr_buffer[3*BUF +: BUF] = ~b;
    ch_wr_addr[3*AW +: AW] = 32'hDEAD0000;
    wait_empty("wr_toggle", 100);
    check_val("toggle_beat_span", TW'(last_wb - first_wb), TW'(2 * (BL - 1)));
    tog_mode = 1'b0;
    ch_wr_en = '0;
    step(2);

    // early tlast on beat 3 plus a stalled read command
    check_val("err_before", TW'(err_tlast), '0);
    tlast_beat = 3;
    ra_hold = 4;
    rd_seed = 32'h55;
    ch_rd_addr[0*AW +: AW] = 32'h5000;
    push_txn(1'b0, 0, 32'h5000, mk_rd(32'h55), -1);
    ch_rd_en[0] = 1'b1;
    wait_empty("rd_bad_tlast", 100);
    check_val("err_set", TW'(err_tlast), TW'(1));
    ch_rd_en = '0;
    step(3);
    check_val("err_sticky", TW'(err_tlast), TW'(1));
    tlast_beat = BL - 1;

    // reset during write beat 4: abandoned, no done, ch0 granted first after
    b = rnd_buf();
    ch_wr_buffer[2*BUF +: BUF] = b;
    ch_wr_addr[2*AW +: AW] = 32'h6000;
    ch_wr_en[2] = 1'b1;
    n = 0;
    while (wr_k < 4 && n < 100) begin
      step(1);
      n++;
    end
    check_val("beat4_reached", TW'(wr_k >= 4), TW'(1));
    #2;
    rstn = 1'b0;
    #1;
    reset_outputs("midrst");
    ch_wr_addr[0*AW +: AW] = 32'h7000;
    ch_wr_en[0] = 1'b1;
    step(3);
    rstn = 1'b1;
    push_txn(1'b1, 0, 32'h7000, ch_wr_buffer[0*BUF +: BUF], 10);
    push_txn(1'b1, 2, 32'h6000, b, 10);
    wait_empty("after_rst", 200);
    ch_wr_en = '0;
    step(5);

    check_val("sb_empty", TW'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
